// File: rtl/display_scan_ctrl_pkg.sv
// display_scan_ctrl_pkg: scan FSM state encoding and index-width helper shared by the display scan controller.
package display_scan_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, GUARD = 2'd2} state_t;
  function automatic int clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// scan_timer: loadable down-counter with terminal-count flag, cleared on rst or clr.
module scan_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc
);
  assign tc = cnt == '0;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (!tc) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexes one seven-segment decoder across NUM_DIGITS digits with guard gaps and leading-zero blanking;
// `define DISPLAY_SCAN_BLINK_EN adds a blink input that darkens every other frame.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000,
  parameter int GUARD_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    lz_blank,
`ifdef DISPLAY_SCAN_BLINK_EN
  input  logic                    blink,
`endif
  output logic [3:0]              hex_out,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    frame_done
);
  localparam int IW = clog2(NUM_DIGITS);
  localparam int CW = clog2((TICK_DIV > GUARD_CYC ? TICK_DIV : GUARD_CYC) + 1);
  state_t state, nxt_state;
  logic [IW-1:0] idx, nxt_idx;
  logic [4*NUM_DIGITS-1:0] shadow, active, nxt_active;
  logic [NUM_DIGITS-1:0] sel_d;
  logic [CW-1:0] cnt;
  logic pending, frame_start, tmr_load, tc, last_dig, blank, dark, fd_d;
  assign hex_out  = active[{idx, 2'b00} +: 4];
  assign last_dig = idx == IW'(NUM_DIGITS - 1);
`ifdef DISPLAY_SCAN_BLINK_EN
  logic parity;
  // parity flips on the edge that starts the next frame, so a whole frame sees one value
  assign dark = blink & (parity ^ frame_done);
  always_ff @(posedge clk) begin
    if (rst) parity <= 1'b0;
    else parity <= parity ^ frame_done;
  end
`else
  assign dark = 1'b0;
`endif
  always_comb begin
    nxt_state = state;
    if (!en) nxt_state = IDLE;
    else if (state == IDLE) nxt_state = ON;
    else if (state == ON && tc) nxt_state = GUARD;
    else if (state == GUARD && tc) nxt_state = ON;
    nxt_idx     = (!en || state == IDLE) ? '0 : (state == GUARD && tc) ? (last_dig ? '0 : idx + 1'b1) : idx;
    frame_start = nxt_state == ON && nxt_idx == '0 && state != ON;
    nxt_active  = (frame_start && pending) ? shadow : active;
    tmr_load    = nxt_state != state && nxt_state != IDLE;
    fd_d        = en && last_dig && ((state == ON && tc && GUARD_CYC == 1) || (state == GUARD && cnt == CW'(1)));
    blank       = (lz_blank && nxt_idx != '0 && (nxt_active >> {nxt_idx, 2'b00}) == '0) || dark;
    sel_d       = (nxt_state == ON && !blank) ? ~(NUM_DIGITS'(1) << nxt_idx) : '1;
  end
  scan_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (!en),
    .load     (tmr_load),
    .load_val (nxt_state == ON ? CW'(TICK_DIV - 1) : CW'(GUARD_CYC - 1)),
    .cnt      (cnt),
    .tc       (tc)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      shadow      <= '0;
      active      <= '0;
      pending     <= 1'b0;
      digit_sel_n <= '1;
      frame_done  <= 1'b0;
    end else begin
      state       <= nxt_state;
      idx         <= nxt_idx;
      active      <= nxt_active;
      if (load) shadow <= value_in;
      pending     <= load | (pending & ~frame_start);
      digit_sel_n <= sel_d;
      frame_done  <= fd_d;
    end
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench; expected per-cycle outputs are queued from frame timing and popped each clock.
module tb_display_scan_ctrl;
  localparam int N = 4, T = 4, G = 2, FL = N * (T + G);
  typedef struct packed {logic [3:0] sel; logic [3:0] hex; logic fd;} exp_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0, lz_blank = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0] hex_out, digit_sel_n;
  logic frame_done;
  exp_t q[$];
  int tests = 0, fails = 0;
`ifdef DISPLAY_SCAN_BLINK_EN
  logic blink = 1'b0;
`endif
  always #5 clk = ~clk;
  display_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(T), .GUARD_CYC(G)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .value_in    (value_in),
    .lz_blank    (lz_blank),
`ifdef DISPLAY_SCAN_BLINK_EN
    .blink       (blink),
`endif
    .hex_out     (hex_out),
    .digit_sel_n (digit_sel_n),
    .frame_done  (frame_done)
  );
  task automatic push_idle(input logic [3:0] h);
    exp_t e;
    e.sel = 4'hF;
    e.hex = h;
    e.fd  = 1'b0;
    q.push_back(e);
  endtask
  task automatic push_frame(input logic [15:0] v, input logic lz, input logic drk, input int n);
    for (int c = 0; c < n; c++) begin
      int d;
      exp_t e;
      logic [15:0] r;
      d = c / (T + G);
      r = v >> (4 * d);
      e.hex = r[3:0];
      e.fd  = c == FL - 1;
      e.sel = ((c % (T + G)) < T && !drk && !(lz && d > 0 && r == 0)) ? ~(4'b1 << d) : 4'hF;
      q.push_back(e);
    end
  endtask
  task automatic tick(output exp_t a, output exp_t e);
    @(posedge clk);
    #1;
    a = {digit_sel_n, hex_out, frame_done};
    e = (q.size() > 0) ? q.pop_front() : 'x;
    tests++;
  endtask
  task automatic test_reset;
    exp_t a, e;
    en = 1'b1;
    push_idle(4'h0);
    push_idle(4'h0);
    for (int i = 0; i < 2; i++) begin
      tick(a, e);
      if (a !== e) begin fails++; $display("FAIL reset[%0d]: got %b expected %b", i, a, e); end
    end
    rst = 1'b0;
    push_frame(16'h0, 1'b0, 1'b0, 1);
    tick(a, e);
    if (a !== e) begin fails++; $display("FAIL reset_first_on: got %b expected %b", a, e); end
    en = 1'b0;
    push_idle(4'h0);
    tick(a, e);
    if (a !== e) begin fails++; $display("FAIL reset_idle: got %b expected %b", a, e); end
  endtask
  task automatic test_load_scan;
    exp_t a, e;
    load = 1'b1;
    value_in = 16'h1234;
    push_idle(4'h0);
    tick(a, e);
    if (a !== e) begin fails++; $display("FAIL load_idle: got %b expected %b", a, e); end
    load = 1'b0;
    en = 1'b1;
    push_frame(16'h1234, 1'b0, 1'b0, FL);
    push_frame(16'h1234, 1'b0, 1'b0, T);
    for (int i = 0; i < FL + T; i++) begin
      tick(a, e);
      if (a !== e) begin fails++; $display("FAIL scan[%0d]: got %b expected %b", i, a, e); end
    end
  endtask
  task automatic test_back_to_back;
    exp_t a, e;
    en = 1'b0;
    push_idle(4'h4);
    tick(a, e);
    if (a !== e) begin fails++; $display("FAIL b2b_idle: got %b expected %b", a, e); end
    en = 1'b1;
    push_frame(16'h1234, 1'b0, 1'b0, FL);
    push_frame(16'hABCD, 1'b0, 1'b0, FL);
    push_frame(16'h5678, 1'b0, 1'b0, FL);
    push_frame(16'h9ABC, 1'b0, 1'b0, 6);
    for (int i = 0; i < 3 * FL + 6; i++) begin
      tick(a, e);
      if (a !== e) begin fails++; $display("FAIL b2b[%0d]: got %b expected %b", i, a, e); end
      load = (i == 8) || (i == FL + 10) || (i == 2 * FL - 1);
      value_in = (i == 8) ? 16'hABCD : (i == FL + 10) ? 16'h5678 : 16'h9ABC;
    end
    load = 1'b0;
  endtask
  task automatic test_lz_blank;
    exp_t a, e;
    en = 1'b0;
    load = 1'b1;
    value_in = 16'h0050;
    push_idle(4'hC);
    tick(a, e);
    if (a !== e) begin fails++; $display("FAIL lz_idle: got %b expected %b", a, e); end
    load = 1'b0;
    en = 1'b1;
    lz_blank = 1'b1;
    push_frame(16'h0050, 1'b1, 1'b0, FL);
    push_frame(16'h0000, 1'b1, 1'b0, FL);
    for (int i = 0; i < 2 * FL; i++) begin
      tick(a, e);
      if (a !== e) begin fails++; $display("FAIL lz[%0d]: got %b expected %b", i, a, e); end
      load = i == 5;
      value_in = 16'h0000;
    end
    load = 1'b0;
  endtask
  task automatic test_abort;
    exp_t a, e;
    en = 1'b0;
    lz_blank = 1'b0;
    load = 1'b1;
    value_in = 16'h1234;
    push_idle(4'h0);
    tick(a, e);
    if (a !== e) begin fails++; $display("FAIL abort_idle: got %b expected %b", a, e); end
    load = 1'b0;
    en = 1'b1;
    push_frame(16'h1234, 1'b0, 1'b0, 14);
    for (int i = 0; i < 14; i++) begin
      tick(a, e);
      if (a !== e) begin fails++; $display("FAIL abort_run[%0d]: got %b expected %b", i, a, e); end
    end
    en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      push_idle(4'h4);
      tick(a, e);
      if (a !== e) begin fails++; $display("FAIL abort_off[%0d]: got %b expected %b", i, a, e); end
    end
    en = 1'b1;
    push_frame(16'h1234, 1'b0, 1'b0, FL);
    for (int i = 0; i < FL; i++) begin
      tick(a, e);
      if (a !== e) begin fails++; $display("FAIL abort_restart[%0d]: got %b expected %b", i, a, e); end
    end
  endtask
`ifdef DISPLAY_SCAN_BLINK_EN
  task automatic test_blink;
    exp_t a, e;
    rst = 1'b1;
    en = 1'b0;
    push_idle(4'h0);
    tick(a, e);
    if (a !== e) begin fails++; $display("FAIL blink_rst: got %b expected %b", a, e); end
    rst = 1'b0;
    load = 1'b1;
    value_in = 16'h1234;
    push_idle(4'h0);
    tick(a, e);
    if (a !== e) begin fails++; $display("FAIL blink_load: got %b expected %b", a, e); end
    load = 1'b0;
    en = 1'b1;
    blink = 1'b1;
    push_frame(16'h1234, 1'b0, 1'b0, FL);
    push_frame(16'h1234, 1'b0, 1'b1, FL);
    push_frame(16'h1234, 1'b0, 1'b0, FL);
    for (int i = 0; i < 3 * FL; i++) begin
      tick(a, e);
      if (a !== e) begin fails++; $display("FAIL blink[%0d]: got %b expected %b", i, a, e); end
    end
    blink = 1'b0;
  endtask
`endif
  initial begin
    test_reset;
    test_load_scan;
    test_back_to_back;
    test_lz_blank;
    test_abort;
`ifdef DISPLAY_SCAN_BLINK_EN
    test_blink;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexes one shared 4-bit-to-seven-segment decoder across NUM_DIGITS common-anode digits. Holds a double-buffered display value and steps a digit-select state machine with guard (all-off) intervals to prevent ghosting. Supports optional leading-zero blanking. Sits between the value producer (counter or register file) and the decoder/anode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
TICK_DIV, 50000, clock cycles each digit is lit (>=1)
GUARD_CYC, 16, all-off clock cycles between digits (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  scan enable; 0 = all digits off
load  in  1  capture value_in into the shadow register
value_in  in  4*NUM_DIGITS  display value; nibble i drives digit i (digit 0 = least significant)
lz_blank  in  1  1 = suppress leading zero digits
hex_out  out  4  nibble to the shared decoder
digit_sel_n  out  NUM_DIGITS  active-low digit enables, one-hot-low or all ones
frame_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset: shadow=0, active=0, pending=0, state=IDLE, idx=0, counters=0, digit_sel_n=all 1s, frame_done=0. hex_out = active[3:0] = 0.
- hex_out is combinational: active[4*idx +: 4]. All other outputs are registered.
- load=1: shadow <= value_in and pending <= 1 on the next edge. A load during a frame does not change the displayed digits.
- Frame start is any transition into ON with idx=0, from IDLE or from wrap-around. At frame start, if pending, active <= shadow.
  - The transfer uses the shadow value before the same cycle's load.
  - pending clears, unless load=1 in that cycle, in which case pending stays 1.
- FSM:
  - IDLE: digits off, idx=0. If en=1, go to ON next cycle (frame start).
  - ON: digit_sel_n[idx]=0 unless the digit is blanked. Lasts exactly TICK_DIV cycles, then GUARD.
  - GUARD: all digits off. Lasts exactly GUARD_CYC cycles. Then idx <= (idx+1) mod NUM_DIGITS and go to ON. On wrap to 0 it is a frame start, and frame_done pulses in the last GUARD cycle of idx=NUM_DIGITS-1.
- Frame period = NUM_DIGITS*(TICK_DIV+GUARD_CYC) cycles.
- en=0 in any state: next cycle IDLE, digits off, idx=0, counters cleared, no frame_done. The shadow register and pending flag are kept.
- Leading-zero blanking (lz_blank=1): digit i>0 is blanked if nibbles i..NUM_DIGITS-1 of active are all zero. Digit 0 is never blanked. A blanked digit still consumes its ON slot, with its enable held at 1.
- rst overrides en and load in the same cycle.

Optional Feature:
- Macro: DISPLAY_SCAN_BLINK_EN.
- Defined:
  - Adds input blink (1 bit) and a frame-parity flop that toggles at each frame_done and resets to 0.
  - When blink=1 and parity=1, all digits are blanked for the entire frame; the FSM timing is unchanged.
  - Blink is sampled per cycle.
- Undefined: no blink port and no parity flop; behaviour is exactly as above.

Decomposition:
- Shared package: FSM state encoding (IDLE, ON, GUARD as 2-bit localparams) and the digit-index width function clog2(NUM_DIGITS).
- One natural sub-module, scan_timer: a loadable down-counter with a terminal-count pulse, sized to max(TICK_DIV, GUARD_CYC). It is reloaded on state entry and cleared on rst or en=0.

Test Plan (NUM_DIGITS=4, TICK_DIV=4, GUARD_CYC=2):
1. rst for 2 cycles, en=1 → digit_sel_n=4'b1111, hex_out=0, frame_done=0 during reset. First ON starts the cycle after rst drops.
2. load value_in=16'h1234 while idle, then en=1 → digit 0 low for 4 cycles with hex_out=4, then 2 all-off cycles, then digits 1/2/3 show 3/2/1. frame_done pulses at cycle 24, then digit 0 repeats.
3. 16'h1234 displayed, load 16'hABCD at mid-digit-1 → digits 1-3 still show 3,2,1. The next frame shows D,C,B,A. A load coinciding with frame start leaves pending=1 and applies at the following frame.
4. lz_blank=1 with value 16'h0050 → digits 3 and 2 stay 1 during their ON slots, digit 1 shows 5, digit 0 shows 0. With value 16'h0000, only digit 0 lights.
5. en dropped during digit 2 ON → next cycle all off with idx=0. en re-asserted → restart at digit 0, with no frame_done for the aborted frame.
6. DISPLAY_SCAN_BLINK_EN defined, blink=1 → alternate frames fully dark and lit (24 cycles each); frame_done still pulses every frame.
